// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: sequences one shift command onto an 8-bit universal
// shift register (parallel load, then N shifts), then returns the result.
module usr_shift_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [3:0]       cmd_count,
  input  logic             cmd_rotate,
  input  logic             cmd_fill,
  input  logic             stall,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_pload,
  output logic             usr_l_in,
  output logic             usr_r_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_MSB   = 2'b01;
  localparam logic [1:0] SEL_LSB   = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;
  localparam logic [3:0] MAX_SHIFT = 4'd8;

  state_t           state;
  state_t           state_nxt;
  logic             dir_q;
  logic             rot_q;
  logic             fill_q;
  logic [3:0]       rem_q;
  logic [WIDTH-1:0] pload_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       cnt_sat;
  logic             accept;
  logic             shift_en;

  assign cnt_sat  = (cmd_count > MAX_SHIFT) ? MAX_SHIFT
                                            : cmd_count;
  assign accept   = cmd_valid && (state == S_IDLE);
  assign shift_en = (state == S_SHIFT) && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q    <= 1'b0;
      rot_q    <= 1'b0;
      fill_q   <= 1'b0;
      rem_q    <= '0;
      pload_q  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        dir_q   <= cmd_dir;
        rot_q   <= cmd_rotate;
        fill_q  <= cmd_fill;
        rem_q   <= cnt_sat;
        pload_q <= cmd_data;
      end
      if (shift_en) begin
        rem_q <= rem_q - 4'd1;
      end
      if (state == S_DONE) begin
        result_q <= usr_q;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    usr_select = SEL_HOLD;
    usr_l_in   = 1'b0;
    usr_r_in   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        usr_select = SEL_LOAD;
        state_nxt  = (rem_q != 4'd0) ? S_SHIFT
                                     : S_DONE;
      end
      S_SHIFT: begin
        // rotate feeds back the bit about to fall off
        if (dir_q) begin
          usr_l_in = rot_q ? usr_q[0] : fill_q;
        end else begin
          usr_r_in = rot_q ? usr_q[WIDTH-1] : fill_q;
        end
        if (!stall) begin
          usr_select = dir_q ? SEL_LSB : SEL_MSB;
          if (rem_q == 4'd1) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // usr_q already holds the final value during DONE
  assign result    = (state == S_DONE) ? usr_q : result_q;
  assign usr_pload = pload_q;

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// tb_usr_shift_ctrl: drives usr_shift_ctrl against a behavioural USR,
// scoreboarding results and checking per-cycle select/latency.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic       cmd_rotate;
  logic       cmd_fill;
  logic       stall;
  logic [7:0] usr_q = '0;
  logic [1:0] usr_select;
  logic [7:0] usr_pload;
  logic       usr_l_in;
  logic       usr_r_in;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  usr_shift_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_count  (cmd_count),
    .cmd_rotate (cmd_rotate),
    .cmd_fill   (cmd_fill),
    .stall      (stall),
    .usr_q      (usr_q),
    .usr_select (usr_select),
    .usr_pload  (usr_pload),
    .usr_l_in   (usr_l_in),
    .usr_r_in   (usr_r_in),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // behavioural 8-bit universal shift register
  always @(posedge clk) begin
    case (usr_select)
      2'b01:   usr_q <= {usr_q[6:0], usr_r_in};
      2'b10:   usr_q <= {usr_l_in, usr_q[7:1]};
      2'b11:   usr_q <= usr_pload;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(
    input logic [7:0] d, input logic dir,
    input logic [3:0] cnt, input logic rot,
    input logic fill);
    logic [7:0] q;
    int n;
    q = d;
    n = (cnt > 4'd8) ? 8 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      if (!dir) q = {q[6:0], rot ? q[7] : fill};
      else      q = {rot ? q[0] : fill, q[7:1]};
    end
    return q;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spur_done", 1, 0);
      end else begin
        chk("result", result, sb.pop_front());
      end
    end
  end

  task automatic run(input logic [7:0] d, input logic dir,
                     input logic [3:0] cnt, input logic rot,
                     input logic fill, input int st_at,
                     input int st_len, input int rej_at,
                     input int rst_at);
    int   lat;
    int   n;
    bit   seen;
    logic [1:0] esel;
    n    = (cnt > 4'd8) ? 8 : int'(cnt);
    lat  = n + st_len + 2;
    seen = 1'b0;
    @(negedge clk);
    chk("ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_data   = d;
    cmd_dir    = dir;
    cmd_count  = cnt;
    cmd_rotate = rot;
    cmd_fill   = fill;
    sb.push_back(model(d, dir, cnt, rot, fill));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      stall     = (cyc >= st_at) && (cyc < st_at + st_len);
      cmd_valid = (cyc == rej_at);
      cmd_data  = (cyc == rej_at) ? ~d : d;
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_sel", usr_select, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        seen  = 1'b1;
        break;
      end
      #1;
      if (cyc == 1)        esel = 2'b11;
      else if (cyc >= lat) esel = 2'b00;
      else if (stall)      esel = 2'b00;
      else                 esel = dir ? 2'b10 : 2'b01;
      chk("sel", usr_select, esel);
      chk("busy", busy, 1);
      if (cyc >= 2 && cyc < lat)
        chk("idle_pin", dir ? usr_r_in : usr_l_in, 0);
      if (cyc == rej_at) begin
        chk("rej_ready", cmd_ready, 0);
        chk("rej_pload", usr_pload, d);
      end
      if (done) begin
        chk("latency", cyc, lat);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("timeout", 0, 1);
    cmd_valid = 1'b0;
    stall     = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_dir    = 1'b0;
    cmd_count  = '0;
    cmd_rotate = 1'b0;
    cmd_fill   = 1'b0;
    stall      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("r_ready", cmd_ready, 1);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_result", result, 0);
    chk("r_sel", usr_select, 0);
    chk("r_pload", usr_pload, 0);
    chk("r_lin", usr_l_in, 0);
    chk("r_rin", usr_r_in, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'h96, 0, 4'd3,  0, 1, 0, 0, 0, 0);
    run(8'h96, 1, 4'd4,  1, 0, 0, 0, 0, 0);
    run(8'h96, 0, 4'd8,  1, 0, 0, 0, 0, 0);
    run(8'h00, 1, 4'd12, 0, 1, 0, 0, 0, 0);
    run(8'h5A, 0, 4'd0,  0, 0, 0, 0, 0, 0);
    run(8'hF0, 1, 4'd2,  0, 0, 3, 3, 0, 0);
    run(8'hA5, 0, 4'd5,  0, 0, 0, 0, 3, 0);
    run(8'h3C, 1, 4'd8,  1, 0, 0, 0, 0, 4);
    repeat (3) @(negedge clk);
    run(8'hC3, 1, 4'd3,  0, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt, 8);
    chk("sb_empty", sb.size(), 0);
    chk("held_res", result, 8'hF8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_shift_ctrl.md
# usr_shift_ctrl

Command sequencer for the team's 8-bit universal shift register (USR). It accepts one shift command at a time: data, direction, count and fill/rotate mode. It drives the USR's select, parallel-load and serial-in pins through a load-then-shift sequence, and returns the final register value with a done pulse. It sits between a register-mapped command source and one USR instance and owns that USR exclusively.

## Interface
- `WIDTH`, 8: USR data width; fixed at 8 for this revision.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller idle and able to accept a command.
- `cmd_data` in 8: value parallel-loaded into the USR.
- `cmd_dir` in 1: 0 shifts toward MSB (USR select 01, serial bit on `usr_r_in` enters bit 0); 1 shifts toward LSB (select 10, serial bit on `usr_l_in` enters bit 7).
- `cmd_count` in 4: number of shifts, 0..8; values 9..15 saturate to 8.
- `cmd_rotate` in 1: 1 feeds back the bit leaving the USR; 0 shifts in `cmd_fill`.
- `cmd_fill` in 1: fill bit, used when `cmd_rotate`=0.
- `stall` in 1: while high in SHIFT, hold the USR (select 00) and freeze the counter.
- `usr_q` in 8: USR parallel output, used for rotate feedback and the result.
- `usr_select` out 2: 00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load.
- `usr_pload` out 8: USR parallel-load data.
- `usr_l_in` out 1: serial bit into USR bit 7.
- `usr_r_in` out 1: serial bit into USR bit 0.
- `busy` out 1: high from command accept until the DONE cycle completes.
- `done` out 1: one-cycle pulse when the result is valid.
- `result` out 8: final USR value; held until the next `done`.

## Operation
- Four-state FSM: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `cmd_ready`=1, `usr_select`=00.
  - On `cmd_valid`&&`cmd_ready`: latch dir, saturated count, rotate and fill, and drive `usr_pload` with `cmd_data`, then go to LOAD.
- **LOAD**
  - `usr_select`=11 for one cycle; the USR captures `usr_pload` at the end of the cycle.
  - Next state is SHIFT if count>0, otherwise DONE.
- **SHIFT**
  - `usr_select` is 01 (dir 0) or 10 (dir 1).
  - One shift per non-stalled cycle; a 4-bit remaining-count register decrements per shift.
  - When the last shift is issued (remaining=1, no stall), go to DONE.
  - Serial bit is combinational from `usr_q`:
    - dir 0, rotate: `usr_r_in` = `usr_q[7]`.
    - dir 1, rotate: `usr_l_in` = `usr_q[0]`.
    - Not rotating: the active serial pin equals the latched fill bit.
  - The inactive serial pin is driven 0.
  - With `stall`=1: `usr_select`=00 and the count is unchanged.
- **DONE**
  - `usr_select`=00, `done`=1, `result` is loaded from `usr_q`.
  - Next state is IDLE.
- `cmd_valid` while not ready is ignored; it is neither queued nor flagged.
- `stall` has no effect in LOAD, DONE or IDLE.
- `usr_pload` holds the last accepted data outside LOAD. It is don't-care to the USR but is deterministic.

## Timing
- **Reset values:** state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `result`=0, `usr_select`=00, `usr_pload`=0, `usr_l_in`=0, `usr_r_in`=0.
- **Latency:** if the accept edge is E0, LOAD occupies the cycle after E0. SHIFT occupies the next N+S cycles (N=count, S=stalled cycles). `done` is high in the cycle after the last shift edge.
  - Total from accept edge to `done` cycle is N+S+2 cycles.
  - Count 0: `done` is high 2 cycles after accept.
- **Throughput:** `cmd_ready` returns high the cycle after DONE, so commands can be accepted back to back at one per N+S+3 cycles.
- **Reset mid-operation:** all outputs go to their reset values immediately (asynchronous). There is no `done`, and the USR contents are left undefined.
- **Stall on the last remaining shift:** DONE is entered only after that shift is actually issued.

## Test plan
Each scenario pairs the controller with the 8-bit USR.

- **Fill toward MSB:** `cmd_data`=8'h96, dir 0, count 3, rotate 0, fill 1 → `result`=8'hB7, `done` 5 cycles after accept, select sequence 11,01,01,01,00.
- **Rotate toward LSB:** 8'h96, dir 1, count 4, rotate 1 → `result`=8'h69. Rotate toward MSB with count 8 → `result`=8'h96.
- **Saturation and zero count:** 8'h00, dir 1, count 12, fill 1 → 8 shifts, `result`=8'hFF. Count 0 with 8'h5A → `result`=8'h5A, `done` 2 cycles after accept.
- **Stall:** 8'hF0, dir 1, count 2, fill 0, `stall` high for 3 cycles mid-SHIFT → `result`=8'h3C, `done` 7 cycles after accept, USR held during the stall.
- **Busy rejection and reset:**
  - Second `cmd_valid` during SHIFT → ignored; exactly one `done`.
  - `rst` pulsed mid-SHIFT → `usr_select`=00, `busy`=0, `cmd_ready`=1 asynchronously, no `done`.
  - A new command after reset then completes normally.
